// File: rtl/alu_cdb_stage.sv
// Integer execute stage feeding the ALU CDB channel through a small result queue.
// Optional macro ALU_BRANCH_RESOLVE_EN: resolve jump/branch targets here instead of in the ROB.
module alu_cdb_stage #(
   parameter int DATA_W = 32,
   parameter int ROB_W  = 4,
   parameter int OP_W   = 6,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              clr,
   input  logic              ALU_S,
   input  logic [OP_W-1:0]   ALU_Op,
   input  logic [DATA_W-1:0] ALU_Vj,
   input  logic [DATA_W-1:0] ALU_Vk,
   input  logic [DATA_W-1:0] ALU_A,
   input  logic [DATA_W-1:0] ALU_pc,
   input  logic [ROB_W-1:0]  ALU_Reorder,
   input  logic              CDB_grant,
   output logic              CDB_ALU_S,
   output logic [ROB_W-1:0]  CDB_ALU_Reorder,
   output logic [DATA_W-1:0] CDB_ALU_Value,
   output logic              CDB_ALU_Jump,
   output logic [DATA_W-1:0] CDB_ALU_Target,
   output logic              ALU_full,
   output logic              ALU_overflow
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [OP_W-1:0] OP_LUI   = OP_W'(1);
   localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(2);
   localparam logic [OP_W-1:0] OP_JAL   = OP_W'(3);
   localparam logic [OP_W-1:0] OP_JALR  = OP_W'(4);
   localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(5);
   localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6);
   localparam logic [OP_W-1:0] OP_BLT   = OP_W'(7);
   localparam logic [OP_W-1:0] OP_BGE   = OP_W'(8);
   localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(9);
   localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(10);
   localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(11);
   localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(12);
   localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(13);
   localparam logic [OP_W-1:0] OP_XORI  = OP_W'(14);
   localparam logic [OP_W-1:0] OP_ORI   = OP_W'(15);
   localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(16);
   localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(17);
   localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(18);
   localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(19);
   localparam logic [OP_W-1:0] OP_ADD   = OP_W'(20);
   localparam logic [OP_W-1:0] OP_SUB   = OP_W'(21);
   localparam logic [OP_W-1:0] OP_SLL   = OP_W'(22);
   localparam logic [OP_W-1:0] OP_SLT   = OP_W'(23);
   localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(24);
   localparam logic [OP_W-1:0] OP_XOR   = OP_W'(25);
   localparam logic [OP_W-1:0] OP_SRL   = OP_W'(26);
   localparam logic [OP_W-1:0] OP_SRA   = OP_W'(27);
   localparam logic [OP_W-1:0] OP_OR    = OP_W'(28);
   localparam logic [OP_W-1:0] OP_AND   = OP_W'(29);

   logic [DATA_W-1:0] w_pc4;
   logic [DATA_W-1:0] w_value;
   logic [DATA_W-1:0] w_branch_value;
   logic              w_cond;
   logic              w_push;
   logic              w_pop;
   logic              w_drop;
   logic              w_qfull;

   logic [PTR_W-1:0]  r_head;
   logic [PTR_W-1:0]  r_tail;
   logic [CNT_W-1:0]  r_count;
   logic              r_overflow;
   logic [DATA_W-1:0] r_value [DEPTH];
   logic [ROB_W-1:0]  r_tag   [DEPTH];

   assign w_pc4 = ALU_pc + DATA_W'(4);

   always_comb begin
      w_cond = 1'b0;
      case (ALU_Op)
         OP_BEQ:  w_cond = (ALU_Vj == ALU_Vk);
         OP_BNE:  w_cond = (ALU_Vj != ALU_Vk);
         OP_BLT:  w_cond = ($signed(ALU_Vj) < $signed(ALU_Vk));
         OP_BGE:  w_cond = ($signed(ALU_Vj) >= $signed(ALU_Vk));
         OP_BLTU: w_cond = (ALU_Vj < ALU_Vk);
         OP_BGEU: w_cond = (ALU_Vj >= ALU_Vk);
         default: w_cond = 1'b0;
      endcase
   end

   // Without local resolution the ROB needs the branch outcome, so it rides in Value bit 0.
`ifdef ALU_BRANCH_RESOLVE_EN
   assign w_branch_value = '0;
`else
   assign w_branch_value = {{(DATA_W-1){1'b0}}, w_cond};
`endif

   always_comb begin
      w_value = '0;
      case (ALU_Op)
         OP_LUI:   w_value = ALU_A;
         OP_AUIPC: w_value = ALU_pc + ALU_A;
         OP_JAL, OP_JALR: w_value = w_pc4;
         OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: w_value = w_branch_value;
         OP_ADDI:  w_value = ALU_Vj + ALU_A;
         OP_SLTI:  w_value = {{(DATA_W-1){1'b0}}, ($signed(ALU_Vj) < $signed(ALU_A))};
         OP_SLTIU: w_value = {{(DATA_W-1){1'b0}}, (ALU_Vj < ALU_A)};
         OP_XORI:  w_value = ALU_Vj ^ ALU_A;
         OP_ORI:   w_value = ALU_Vj | ALU_A;
         OP_ANDI:  w_value = ALU_Vj & ALU_A;
         OP_SLLI:  w_value = ALU_Vj << ALU_A[4:0];
         OP_SRLI:  w_value = ALU_Vj >> ALU_A[4:0];
         OP_SRAI:  w_value = $unsigned($signed(ALU_Vj) >>> ALU_A[4:0]);
         OP_ADD:   w_value = ALU_Vj + ALU_Vk;
         OP_SUB:   w_value = ALU_Vj - ALU_Vk;
         OP_SLL:   w_value = ALU_Vj << ALU_Vk[4:0];
         OP_SLT:   w_value = {{(DATA_W-1){1'b0}}, ($signed(ALU_Vj) < $signed(ALU_Vk))};
         OP_SLTU:  w_value = {{(DATA_W-1){1'b0}}, (ALU_Vj < ALU_Vk)};
         OP_XOR:   w_value = ALU_Vj ^ ALU_Vk;
         OP_SRL:   w_value = ALU_Vj >> ALU_Vk[4:0];
         OP_SRA:   w_value = $unsigned($signed(ALU_Vj) >>> ALU_Vk[4:0]);
         OP_OR:    w_value = ALU_Vj | ALU_Vk;
         OP_AND:   w_value = ALU_Vj & ALU_Vk;
         default:  w_value = '0;
      endcase
   end

`ifdef ALU_BRANCH_RESOLVE_EN
   logic              w_jump;
   logic [DATA_W-1:0] w_target;
   logic              r_jump   [DEPTH];
   logic [DATA_W-1:0] r_target [DEPTH];

   always_comb begin
      w_jump   = 1'b0;
      w_target = w_pc4;
      case (ALU_Op)
         OP_JAL: begin
            w_jump   = 1'b1;
            w_target = ALU_pc + ALU_A;
         end
         OP_JALR: begin
            w_jump   = 1'b1;
            w_target = (ALU_Vj + ALU_A) & ~DATA_W'(1);
         end
         OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
            if (w_cond) begin
               w_jump   = 1'b1;
               w_target = ALU_pc + ALU_A;
            end
         end
         default: begin
            w_jump   = 1'b0;
            w_target = w_pc4;
         end
      endcase
   end
`endif

   // A pop frees a slot in the same edge, so a full queue can still accept an issue.
   assign w_qfull = (r_count == CNT_W'(DEPTH));
   assign w_pop   = rdy & (r_count != '0) & CDB_grant & ~clr;
   assign w_push  = rdy & ALU_S & ~clr & (~w_qfull | w_pop);
   assign w_drop  = rdy & ALU_S & ~clr & w_qfull & ~w_pop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            r_value[i] <= '0;
            r_tag[i]   <= '0;
`ifdef ALU_BRANCH_RESOLVE_EN
            r_jump[i]   <= 1'b0;
            r_target[i] <= '0;
`endif
         end
      end else if (rdy) begin
         if (clr) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else begin
            if (w_push) begin
               r_value[r_tail] <= w_value;
               r_tag[r_tail]   <= ALU_Reorder;
`ifdef ALU_BRANCH_RESOLVE_EN
               r_jump[r_tail]   <= w_jump;
               r_target[r_tail] <= w_target;
`endif
               r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
               r_head <= r_head + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
               r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
               r_count <= r_count - CNT_W'(1);
            end
            if (w_drop) begin
               r_overflow <= 1'b1;
            end
         end
      end
   end

   assign CDB_ALU_S       = (r_count != '0);
   assign CDB_ALU_Reorder = r_tag[r_head];
   assign CDB_ALU_Value   = r_value[r_head];
`ifdef ALU_BRANCH_RESOLVE_EN
   assign CDB_ALU_Jump    = r_jump[r_head];
   assign CDB_ALU_Target  = r_target[r_head];
`else
   assign CDB_ALU_Jump    = 1'b0;
   assign CDB_ALU_Target  = '0;
`endif
   assign ALU_full        = (r_count >= CNT_W'(DEPTH - 1));
   assign ALU_overflow    = r_overflow;

endmodule

// File: tb/tb_alu_cdb_stage.sv
// Directed bench for alu_cdb_stage; expectations follow ALU_BRANCH_RESOLVE_EN when defined.
module tb_alu_cdb_stage;

   localparam logic [5:0] OP_JAL = 6'd3, OP_JALR = 6'd4, OP_BEQ = 6'd5, OP_BNE = 6'd6;
   localparam logic [5:0] OP_BLT = 6'd7, OP_BLTU = 6'd9, OP_ADDI = 6'd11, OP_SRAI = 6'd19;
   localparam logic [5:0] OP_ADD = 6'd20, OP_SLTU = 6'd24, OP_BAD = 6'd63;
`ifdef ALU_BRANCH_RESOLVE_EN
   localparam bit EN = 1'b1;
`else
   localparam bit EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, rdy, clr, ALU_S, CDB_grant;
   logic [5:0]  ALU_Op;
   logic [31:0] ALU_Vj, ALU_Vk, ALU_A, ALU_pc;
   logic [3:0]  ALU_Reorder;
   logic        CDB_ALU_S, CDB_ALU_Jump, ALU_full, ALU_overflow;
   logic [3:0]  CDB_ALU_Reorder;
   logic [31:0] CDB_ALU_Value, CDB_ALU_Target;

   int checks = 0;
   int failures = 0;

   alu_cdb_stage dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .ALU_S(ALU_S), .ALU_Op(ALU_Op),
      .ALU_Vj(ALU_Vj), .ALU_Vk(ALU_Vk), .ALU_A(ALU_A), .ALU_pc(ALU_pc),
      .ALU_Reorder(ALU_Reorder), .CDB_grant(CDB_grant), .CDB_ALU_S(CDB_ALU_S),
      .CDB_ALU_Reorder(CDB_ALU_Reorder), .CDB_ALU_Value(CDB_ALU_Value),
      .CDB_ALU_Jump(CDB_ALU_Jump), .CDB_ALU_Target(CDB_ALU_Target),
      .ALU_full(ALU_full), .ALU_overflow(ALU_overflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                        input logic [31:0] a, input logic [31:0] pc, input logic [3:0] tag);
      ALU_S = 1'b1; ALU_Op = op; ALU_Vj = vj; ALU_Vk = vk; ALU_A = a; ALU_pc = pc; ALU_Reorder = tag;
   endtask

   task automatic test_reset();
      rst = 1'b0; rdy = 1'b1; clr = 1'b0; ALU_S = 1'b0; CDB_grant = 1'b0;
      ALU_Op = '0; ALU_Vj = '0; ALU_Vk = '0; ALU_A = '0; ALU_pc = '0; ALU_Reorder = '0;
      tick(); tick();
      checks++; if ({CDB_ALU_S, CDB_ALU_Jump, ALU_full, ALU_overflow} !== 4'b0) begin failures++;
         $display("FAIL reset_flags got=%b exp=0000", {CDB_ALU_S, CDB_ALU_Jump, ALU_full, ALU_overflow}); end
      checks++; if ({CDB_ALU_Reorder, CDB_ALU_Value, CDB_ALU_Target} !== 68'h0) begin failures++;
         $display("FAIL reset_data got=%h exp=0", {CDB_ALU_Reorder, CDB_ALU_Value, CDB_ALU_Target}); end
      rst = 1'b1;
      tick();
      $display("reset: S=%0b full=%0b ovf=%0b", CDB_ALU_S, ALU_full, ALU_overflow);
   endtask

   task automatic test_add();
      CDB_grant = 1'b1;
      issue(OP_ADD, 32'd5, 32'd7, 32'd0, 32'h10, 4'd3);
      tick();
      ALU_S = 1'b0;
      checks++; if (CDB_ALU_S !== 1'b1) begin failures++; $display("FAIL add_valid got=%b exp=1", CDB_ALU_S); end
      checks++; if (CDB_ALU_Reorder !== 4'd3) begin failures++; $display("FAIL add_tag got=%0d exp=3", CDB_ALU_Reorder); end
      checks++; if (CDB_ALU_Value !== 32'd12) begin failures++; $display("FAIL add_value got=%0d exp=12", CDB_ALU_Value); end
      $display("add: tag=%0d value=%0d", CDB_ALU_Reorder, CDB_ALU_Value);
      tick();
      checks++; if (CDB_ALU_S !== 1'b0) begin failures++; $display("FAIL add_popped got=%b exp=0", CDB_ALU_S); end
   endtask

   task automatic test_back_to_back();
      CDB_grant = 1'b1;
      issue(OP_SRAI, 32'h8000_0000, 32'd0, 32'd4, 32'h20, 4'd5);
      tick();
      checks++; if (CDB_ALU_Value !== 32'hF800_0000 || CDB_ALU_Reorder !== 4'd5) begin failures++;
         $display("FAIL srai got=%h/%0d exp=f8000000/5", CDB_ALU_Value, CDB_ALU_Reorder); end
      $display("srai: tag=%0d value=%h", CDB_ALU_Reorder, CDB_ALU_Value);
      issue(OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'h24, 4'd6);
      tick();
      ALU_S = 1'b0;
      checks++; if (CDB_ALU_Value !== 32'd1 || CDB_ALU_Reorder !== 4'd6 || CDB_ALU_S !== 1'b1) begin failures++;
         $display("FAIL sltu got=%h/%0d/%b exp=1/6/1", CDB_ALU_Value, CDB_ALU_Reorder, CDB_ALU_S); end
      checks++; if (ALU_full !== 1'b1) begin failures++; $display("FAIL b2b_full got=%b exp=1", ALU_full); end
      $display("sltu: tag=%0d value=%h", CDB_ALU_Reorder, CDB_ALU_Value);
      tick();
      checks++; if (CDB_ALU_S !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", CDB_ALU_S); end
   endtask

   task automatic test_full_overflow();
      CDB_grant = 1'b0;
      checks++; if (ALU_full !== 1'b0) begin failures++; $display("FAIL empty_full got=%b exp=0", ALU_full); end
      issue(OP_ADDI, 32'd10, 32'd0, 32'd1, 32'h30, 4'd1);
      tick();
      checks++; if (ALU_full !== 1'b1) begin failures++; $display("FAIL full_one got=%b exp=1", ALU_full); end
      issue(OP_ADDI, 32'd20, 32'd0, 32'd2, 32'h34, 4'd2);
      tick();
      checks++; if (ALU_overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", ALU_overflow); end
      issue(OP_ADDI, 32'd30, 32'd0, 32'd3, 32'h38, 4'd7);
      tick();
      ALU_S = 1'b0;
      checks++; if (ALU_overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", ALU_overflow); end
      checks++; if (CDB_ALU_Reorder !== 4'd1 || CDB_ALU_Value !== 32'd11) begin failures++;
         $display("FAIL q_first got=%0d/%0d exp=1/11", CDB_ALU_Reorder, CDB_ALU_Value); end
      $display("queue head: tag=%0d value=%0d ovf=%0b", CDB_ALU_Reorder, CDB_ALU_Value, ALU_overflow);
      CDB_grant = 1'b1;
      tick();
      checks++; if (CDB_ALU_Reorder !== 4'd2 || CDB_ALU_Value !== 32'd22 || CDB_ALU_S !== 1'b1) begin failures++;
         $display("FAIL q_second got=%0d/%0d/%b exp=2/22/1", CDB_ALU_Reorder, CDB_ALU_Value, CDB_ALU_S); end
      $display("queue head: tag=%0d value=%0d", CDB_ALU_Reorder, CDB_ALU_Value);
      tick();
      checks++; if ({CDB_ALU_S, ALU_full, ALU_overflow} !== 3'b001) begin failures++;
         $display("FAIL q_drained got=%b exp=001", {CDB_ALU_S, ALU_full, ALU_overflow}); end
   endtask

   task automatic test_branch();
      logic [5:0]  ops  [7] = '{OP_BNE, OP_BEQ, OP_BLT, OP_BLTU, OP_JALR, OP_JAL, OP_BAD};
      logic [31:0] vjs  [7] = '{32'd1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h203, 32'd0, 32'd9};
      logic [31:0] vks  [7] = '{32'd2, 32'd2, 32'd1, 32'd1, 32'd0, 32'd0, 32'd9};
      logic [31:0] as   [7] = '{32'h20, 32'h20, 32'h40, 32'h40, 32'd0, 32'h10, 32'd5};
      logic [31:0] pcs  [7] = '{32'h100, 32'h100, 32'h200, 32'h200, 32'h300, 32'h400, 32'h40};
      logic [31:0] ev   [7];
      logic        ej   [7];
      logic [31:0] et   [7];
      ev = '{EN ? 32'd0 : 32'd1, 32'd0, EN ? 32'd0 : 32'd1, 32'd0, 32'h304, 32'h404, 32'd0};
      ej = '{EN, 1'b0, EN, 1'b0, EN, EN, 1'b0};
      et = '{EN ? 32'h120 : 32'd0, EN ? 32'h104 : 32'd0, EN ? 32'h240 : 32'd0, EN ? 32'h204 : 32'd0,
             EN ? 32'h202 : 32'd0, EN ? 32'h410 : 32'd0, EN ? 32'h44 : 32'd0};
      CDB_grant = 1'b1;
      for (int i = 0; i < 7; i++) begin
         issue(ops[i], vjs[i], vks[i], as[i], pcs[i], 4'(i + 8));
         tick();
         checks++;
         if (CDB_ALU_S !== 1'b1 || CDB_ALU_Reorder !== 4'(i + 8) || CDB_ALU_Value !== ev[i] ||
             CDB_ALU_Jump !== ej[i] || CDB_ALU_Target !== et[i]) begin
            failures++;
            $display("FAIL branch_%0d got=%b/%0d/%h/%b/%h exp=1/%0d/%h/%b/%h", i, CDB_ALU_S, CDB_ALU_Reorder,
                     CDB_ALU_Value, CDB_ALU_Jump, CDB_ALU_Target, i + 8, ev[i], ej[i], et[i]);
         end
         $display("ctrl op=%0d: value=%h jump=%0b target=%h", ops[i], CDB_ALU_Value, CDB_ALU_Jump, CDB_ALU_Target);
      end
      ALU_S = 1'b0;
      tick();
   endtask

   task automatic test_clr();
      CDB_grant = 1'b0;
      issue(OP_ADD, 32'd1, 32'd1, 32'd0, 32'h50, 4'd8);
      tick();
      issue(OP_ADD, 32'd2, 32'd2, 32'd0, 32'h54, 4'd9);
      tick();
      checks++; if (CDB_ALU_S !== 1'b1 || ALU_full !== 1'b1) begin failures++;
         $display("FAIL clr_pre got=%b%b exp=11", CDB_ALU_S, ALU_full); end
      issue(OP_ADD, 32'd3, 32'd3, 32'd0, 32'h58, 4'd10);
      clr = 1'b1; CDB_grant = 1'b1;
      tick();
      clr = 1'b0; ALU_S = 1'b0;
      checks++; if ({CDB_ALU_S, ALU_full} !== 2'b00) begin failures++;
         $display("FAIL clr_empty got=%b exp=00", {CDB_ALU_S, ALU_full}); end
      checks++; if (ALU_overflow !== 1'b1) begin failures++; $display("FAIL clr_ovf_kept got=%b exp=1", ALU_overflow); end
      tick();
      checks++; if (CDB_ALU_S !== 1'b0) begin failures++; $display("FAIL clr_nopush got=%b exp=0", CDB_ALU_S); end
      $display("clr: S=%0b full=%0b ovf=%0b", CDB_ALU_S, ALU_full, ALU_overflow);
   endtask

   task automatic test_rdy();
      CDB_grant = 1'b0;
      issue(OP_ADD, 32'd3, 32'd4, 32'd0, 32'h60, 4'd11);
      tick();
      ALU_S = 1'b0; rdy = 1'b0; CDB_grant = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (CDB_ALU_S !== 1'b1 || CDB_ALU_Reorder !== 4'd11 || CDB_ALU_Value !== 32'd7) begin failures++;
            $display("FAIL rdy_hold_%0d got=%b/%0d/%0d exp=1/11/7", i, CDB_ALU_S, CDB_ALU_Reorder, CDB_ALU_Value); end
      end
      rdy = 1'b1;
      tick();
      checks++; if (CDB_ALU_S !== 1'b0) begin failures++; $display("FAIL rdy_pop got=%b exp=0", CDB_ALU_S); end
      $display("rdy: held 3 cycles, then S=%0b", CDB_ALU_S);
   endtask

   task automatic test_async_reset();
      CDB_grant = 1'b0;
      issue(OP_ADD, 32'd8, 32'd8, 32'd0, 32'h70, 4'd12);
      tick();
      ALU_S = 1'b0;
      checks++; if (CDB_ALU_S !== 1'b1) begin failures++; $display("FAIL ar_pre got=%b exp=1", CDB_ALU_S); end
      #2 rst = 1'b0;
      #1;
      checks++; if ({CDB_ALU_S, ALU_overflow, ALU_full} !== 3'b000 || CDB_ALU_Value !== 32'd0) begin failures++;
         $display("FAIL ar_clear got=%b/%h exp=000/0", {CDB_ALU_S, ALU_overflow, ALU_full}, CDB_ALU_Value); end
      $display("async reset: S=%0b ovf=%0b", CDB_ALU_S, ALU_overflow);
      #1 rst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_full_overflow();
      test_branch();
      test_clr();
      test_rdy();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
